// File: rtl/axi4lite_slv_regs.sv
// ---------------------------------------------------------------------------
// axi4lite_slv_regs
//   AXI4-Lite slave exposing four 32-bit read/write registers. The registers
//   drive the CORDIC rotation core as its control and operand words.
//   wr_commit_o pulses (one-hot, one cycle) on the cycle after a register
//   has been written, so user logic knows which word just changed.
//
// Ports
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   s00_axi_aw* / s00_axi_w*       : write address / write data channels
//   s00_axi_b*                     : write response (always OKAY)
//   s00_axi_ar* / s00_axi_r*       : read address / read data (always OKAY)
//   reg0_o..reg3_o                 : live register contents
//   wr_commit_o                    : one-hot commit strobe per register
// ---------------------------------------------------------------------------
module axi4lite_slv_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_RESET_VAL        = 32'h0
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_commit_o
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  // Write-side holding state: AW and W are captured independently and the
  // pair is committed once both halves are present.
  logic                          aw_full_reg;
  logic                          w_full_reg;
  logic [1:0]                    aw_idx_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_reg;
  logic [NB-1:0]                 wstrb_reg;
  logic                          bvalid_reg;
  logic [3:0]                    wr_commit_reg;

  logic                          rvalid_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;

  // Holding off AW/W while bvalid is up keeps exactly one write outstanding.
  assign s00_axi_awready = !aw_full_reg && !bvalid_reg;
  assign s00_axi_wready  = !w_full_reg && !bvalid_reg;
  assign s00_axi_arready = !rvalid_reg;

  assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_hs   = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign commit = aw_full_reg && w_full_reg && !bvalid_reg;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_full_reg   <= 1'b0;
      w_full_reg    <= 1'b0;
      aw_idx_reg    <= 2'd0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      bvalid_reg    <= 1'b0;
      wr_commit_reg <= 4'd0;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_idx_reg  <= s00_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        wdata_reg  <= s00_axi_wdata;
        wstrb_reg  <= s00_axi_wstrb;
      end
      // commit requires both halves held, so it never coincides with a
      // fresh AW/W handshake; clearing here cannot lose a capture.
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
      end else if (bvalid_reg && s00_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      wr_commit_reg <= commit ? (4'b0001 << aw_idx_reg) : 4'd0;

      // regs[] here is the pre-edge value, so a read captured on the same
      // edge as a commit to the same word returns the old contents.
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= regs[s00_axi_araddr[3:2]];
      end else if (rvalid_reg && s00_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // One storage word per register, byte-lane write enables from wstrb.
  for (genvar gi = 0; gi < 4; gi++) begin : g_reg
    logic [C_S_AXI_DATA_WIDTH-1:0] q_reg;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
        q_reg <= C_RESET_VAL;
      end else if (commit && (aw_idx_reg == 2'(gi))) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb_reg[b]) begin
            q_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
          end
        end
      end
    end

    assign regs[gi] = q_reg;
  end

  assign s00_axi_bvalid = bvalid_reg;
  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rvalid = rvalid_reg;
  assign s00_axi_rdata  = rdata_reg;
  assign s00_axi_rresp  = 2'b00;
  assign wr_commit_o    = wr_commit_reg;

  assign reg0_o = regs[0];
  assign reg1_o = regs[1];
  assign reg2_o = regs[2];
  assign reg3_o = regs[3];

  // Protection bits and byte offsets carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi4lite_slv_regs.sv
module tb_axi4lite_slv_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  wr_commit;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model and scoreboard queues
  logic [31:0] model [4];
  logic [3:0]  exp_commit [$];
  logic [1:0]  exp_b [$];
  logic [31:0] exp_r [$];

  always #5 clk = ~clk;

  axi4lite_slv_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg0_o          (reg0),
    .reg1_o          (reg1),
    .reg2_o          (reg2),
    .reg3_o          (reg3),
    .wr_commit_o     (wr_commit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- monitors (sample mid-cycle) ----------------
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (exp_b.size() == 0) timeout("unexpected_bresp");
      else begin
        logic [1:0] e;
        e = exp_b.pop_front();
        $display("B  bresp=%0d exp=%0d", bresp, e);
        check("bresp", 32'(bresp), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (exp_r.size() == 0) timeout("unexpected_rvalid");
      else begin
        logic [31:0] e;
        e = exp_r.pop_front();
        $display("R  rdata=%h exp=%h rresp=%0d", rdata, e, rresp);
        check("rdata", rdata, e);
        check("rresp", 32'(rresp), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && wr_commit != 4'd0) begin
      if (exp_commit.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL wr_commit: got %b expected no pulse", wr_commit);
      end else begin
        logic [3:0] e;
        e = exp_commit.pop_front();
        $display("C  wr_commit=%b exp=%b", wr_commit, e);
        check("wr_commit", 32'(wr_commit), 32'(e));
        check("commit_with_bvalid", 32'(bvalid), 32'd1);
      end
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic send_aw(input logic [3:0] a, input int dly);
    bit ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) timeout("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    if (!ok) timeout("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] a);
    bit ok = 0;
    araddr = a; arvalid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && exp_r.size() == 0 && exp_commit.size() == 0) begin
        ok = 1; break;
      end
    end
    if (!ok) begin
      timeout("scoreboard_drain");
      exp_b.delete(); exp_r.delete(); exp_commit.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_commit.push_back(4'b0001 << a[3:2]);
    exp_b.push_back(2'b00);
    model[a[3:2]] = merge(model[a[3:2]], d, s);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int wdly, input int awdly);
    expect_write(a, d, s);
    fork
      send_aw(a, awdly);
      send_w(d, s, wdly);
    join
    wait_idle();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] e);
    exp_r.push_back(e);
    send_ar(a);
    wait_idle();
  endtask

  task automatic check_regs(input string name);
    check({name, "_reg0"}, reg0, model[0]);
    check({name, "_reg1"}, reg1, model[1]);
    check({name, "_reg2"}, reg2, model[2]);
    check({name, "_reg3"}, reg3, model[3]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_commit", 32'(wr_commit), 32'd0);
    check_regs("rst");
    @(posedge clk); #1;

    // Sequential write 1..4 then readback
    for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 32'(i + 1));
    check_regs("seq");

    // Byte strobes
    do_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0);
    do_write(4'h4, 32'h11223344, 4'b0101, 0, 0);
    do_read(4'h4, 32'hAA22CC44);

    // W ahead of AW
    expect_write(4'h8, 32'h5A5A5A5A, 4'hF);
    send_w(32'h5A5A5A5A, 4'hF, 0);
    @(negedge clk);
    check("w_early_wready_low", 32'(wready), 32'd0);
    check("w_early_awready_high", 32'(awready), 32'd1);
    @(posedge clk); #1;
    send_aw(4'h8, 1);
    @(negedge clk);
    check("bvalid_not_yet", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("bvalid_after_commit", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    wait_idle();
    check("reg2_w_early", reg2, 32'h5A5A5A5A);

    // bready held low with a second write pending
    bready = 1'b0;
    expect_write(4'h0, 32'h000000A1, 4'hF);
    fork
      send_aw(4'h0, 0);
      send_w(32'h000000A1, 4'hF, 0);
    join
    repeat (2) begin @(posedge clk); #1; end
    expect_write(4'h1, 32'h000000B2, 4'hF);
    fork
      send_aw(4'h1, 0);
      send_w(32'h000000B2, 4'hF, 0);
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("stall_awready", 32'(awready), 32'd0);
          check("stall_wready", 32'(wready), 32'd0);
          check("stall_bvalid", 32'(bvalid), 32'd1);
          check("stall_commit", 32'(wr_commit), 32'd0);
          check("stall_reg0", reg0, 32'h000000A1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
      end
    join
    wait_idle();
    check("reg0_after_stall", reg0, 32'h000000B2);

    // Read captured on the same edge as a commit to the same register
    expect_write(4'hC, 32'h99, 4'hF);
    exp_r.push_back(32'd4);
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("same_edge_aw_ready", 32'(awready & wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'hC; arvalid = 1'b1;
    @(negedge clk);
    check("same_edge_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_idle();
    do_read(4'hF, 32'h99);

    // Randomised traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, model[a[3:2]]);
    end
    check_regs("random");

    // Reset while a read response is held
    rready = 1'b0;
    send_ar(4'h4);
    @(negedge clk);
    check("pre_reset_rvalid", 32'(rvalid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_rvalid", 32'(rvalid), 32'd0);
    check("async_rst_arready", 32'(arready), 32'd1);
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    check_regs("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    rready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 32'h0);

    check("final_queues", 32'(exp_b.size() + exp_r.size() + exp_commit.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
